// File: rtl/prores_scan_pkg.sv
// Shared ProRes scan constants and the progressive scan-position lookup,
// used by both the coefficient reader and the VLC-to-memory writer.
`timescale 1ns/1ps
package prores_scan_pkg;

  localparam int MAX_BLOCK_NUM = 32;
  localparam int MAX_PIXEL_NUM = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH
  } state_t;

  // Scan index -> natural (row-major) position inside an 8x8 block.
  localparam logic [5:0] SCAN_TABLE [64] = '{
    6'd0,  6'd1,  6'd8,  6'd9,  6'd2,  6'd3,  6'd10, 6'd11,
    6'd16, 6'd17, 6'd24, 6'd25, 6'd18, 6'd19, 6'd26, 6'd27,
    6'd4,  6'd5,  6'd12, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14,
    6'd21, 6'd28, 6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd31,
    6'd32, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34, 6'd35, 6'd42,
    6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36, 6'd37, 6'd44,
    6'd51, 6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  function automatic logic [5:0] scan_pos(input logic [5:0] idx);
    return SCAN_TABLE[idx];
  endfunction

endpackage

// File: rtl/ac_vlc_to_mem.sv
// Writes decoded AC coefficients of a slice (coefficient-major, block-minor)
// into coefficient memory at block*64 + natural position.
`timescale 1ns/1ps
module ac_vlc_to_mem #(
  parameter int MAX_BLOCK_NUM = prores_scan_pkg::MAX_BLOCK_NUM,
  parameter int MAX_PIXEL_NUM = prores_scan_pkg::MAX_PIXEL_NUM
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] block_num,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [10:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        done,
  output logic        err
);
  import prores_scan_pkg::*;

  state_t      state, state_nxt;
  logic [5:0]  k_cnt;
  logic [31:0] b_cnt;
  logic [31:0] blocks_lat;
  logic        accept;
  logic        last_blk;
  logic        last_k;
  logic        start_ok;

  assign accept   = in_valid && in_ready;
  assign last_blk = (b_cnt == blocks_lat - 32'd1);
  assign last_k   = (k_cnt == 6'(MAX_PIXEL_NUM - 1));
  assign start_ok = (block_num != '0) && (block_num <= 32'(MAX_BLOCK_NUM));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (start && start_ok) state_nxt = ST_RUN;
      ST_RUN:   if (accept && last_k && last_blk) state_nxt = ST_FLUSH;
      ST_FLUSH: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == ST_RUN);
  end

  // done is raised both when leaving FLUSH and one cycle after a rejected start.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      k_cnt      <= 6'd1;
      b_cnt      <= '0;
      blocks_lat <= '0;
    end else begin
      mem_we <= accept;
      done   <= (state == ST_FLUSH);
      if (accept) begin
        mem_addr  <= 11'((b_cnt << 6) | 32'(scan_pos(k_cnt)));
        mem_wdata <= in_data;
        if (last_blk) begin
          b_cnt <= '0;
          k_cnt <= k_cnt + 6'd1;
        end else begin
          b_cnt <= b_cnt + 32'd1;
        end
      end
      if (state == ST_IDLE && start) begin
        if (start_ok) begin
          blocks_lat <= block_num;
          k_cnt      <= 6'd1;
          b_cnt      <= '0;
          err        <= 1'b0;
        end else begin
          err  <= 1'b1;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ac_vlc_to_mem.sv
// Scoreboard bench for ac_vlc_to_mem: directed slices push expected writes,
// a negedge monitor pops and compares every memory write.
`timescale 1ns/1ps
module tb_ac_vlc_to_mem;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] block_num = '0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready, mem_we, done, err;
  logic [10:0] mem_addr;
  logic [31:0] mem_wdata;

  typedef struct {
    logic [10:0] addr;
    logic [31:0] data;
  } wr_t;

  int  tests = 0;
  int  fails = 0;
  wr_t exp_q[$];
  wr_t log_q[$];
  int  hits[2048];
  int  wr_cnt = 0;
  int  done_cnt = 0;

  int scan_tab [64] = '{
     0,  1,  8,  9,  2,  3, 10, 11,
    16, 17, 24, 25, 18, 19, 26, 27,
     4,  5, 12, 20, 13,  6,  7, 14,
    21, 28, 29, 22, 15, 23, 30, 31,
    32, 33, 40, 48, 41, 34, 35, 42,
    49, 56, 57, 50, 43, 36, 37, 44,
    51, 58, 59, 52, 45, 38, 39, 46,
    53, 60, 61, 54, 47, 55, 62, 63
  };

  always #5 clock = ~clock;

  ac_vlc_to_mem #(.MAX_BLOCK_NUM(32), .MAX_PIXEL_NUM(64)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .block_num(block_num),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .done(done), .err(err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n) begin
      if (done) done_cnt++;
      if (mem_we) begin
        wr_t e;
        wr_cnt++;
        hits[mem_addr]++;
        log_q.push_back('{mem_addr, mem_wdata});
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: got addr %0d data %0d expected no write", mem_addr, mem_wdata);
        end else begin
          e = exp_q.pop_front();
          check("write_addr_data", {21'b0, mem_addr, mem_wdata}, {21'b0, e.addr, e.data});
        end
      end
    end
  end

  task automatic beat(input logic [31:0] d, output bit ok);
    in_valid = 1'b1;
    in_data  = d;
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clock);
      if (in_ready) begin
        ok = 1'b1;
        @(posedge clock);
        #1;
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_beats(input int bn, input int first, input int count, input bit gaps);
    bit ok;
    for (int i = first; i < first + count; i++) begin
      int k = 1 + i / bn;
      int b = i % bn;
      exp_q.push_back('{11'(b * 64 + scan_tab[k]), 32'(i)});
      if (gaps) repeat ($urandom_range(0, 3)) @(posedge clock);
      #1;
      beat(32'(i), ok);
      if (!ok) begin
        tests++;
        fails++;
        $display("FAIL accept_timeout: beat %0d not accepted, required accept within 20 cycles", i);
        return;
      end
    end
  endtask

  task automatic do_start(input logic [31:0] bn);
    @(posedge clock);
    #1;
    start = 1'b1;
    block_num = bn;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit found = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clock);
      if (done) begin
        found = 1'b1;
        break;
      end
    end
    check(name, 64'(found), 64'd1);
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0, d0, bad;
    logic [31:0] bad_blocks [2] = '{32'd0, 32'd33};

    #1;
    check("reset_outputs", 64'({in_ready, mem_we, mem_addr, mem_wdata, done, err}), 64'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // Two blocks, continuous stream, exact done latency.
    do_start(32'd2);
    wr0 = wr_cnt; d0 = done_cnt; log_q.delete();
    send_beats(2, 0, 126, 1'b0);
    @(negedge clock);
    check("flush_in_ready", 64'(in_ready), 64'd0);
    check("done_not_in_flush", 64'(done), 64'd0);
    @(negedge clock);
    check("done_latency", 64'(done), 64'd1);
    @(negedge clock);
    check("done_pulse_width", 64'(done), 64'd0);
    check("bn2_write_count", 64'(wr_cnt - wr0), 64'd126);
    check("bn2_done_count", 64'(done_cnt - d0), 64'd1);
    check("bn2_log_size", 64'(log_q.size()), 64'd126);
    if (log_q.size() == 126) begin
      check("beat0_addr", 64'(log_q[0].addr), 64'd1);
      check("beat1_addr", 64'(log_q[1].addr), 64'd65);
      check("beat2_addr", 64'(log_q[2].addr), 64'd8);
      check("beat125_addr", 64'(log_q[125].addr), 64'd127);
      check("beat125_data", 64'(log_q[125].data), 64'd125);
    end

    // One block with random valid gaps.
    do_start(32'd1);
    wr0 = wr_cnt;
    send_beats(1, 0, 63, 1'b1);
    wait_done("bn1_done");
    check("bn1_write_count", 64'(wr_cnt - wr0), 64'd63);

    // Illegal block counts.
    foreach (bad_blocks[i]) begin
      wr0 = wr_cnt;
      do_start(bad_blocks[i]);
      @(negedge clock);
      check("illegal_err_set", 64'(err), 64'd1);
      check("illegal_done_pulse", 64'(done), 64'd1);
      check("illegal_in_ready", 64'(in_ready), 64'd0);
      @(negedge clock);
      check("illegal_done_cleared", 64'(done), 64'd0);
      check("illegal_err_sticky", 64'(err), 64'd1);
      check("illegal_in_ready_2", 64'(in_ready), 64'd0);
      check("illegal_no_writes", 64'(wr_cnt - wr0), 64'd0);
    end

    // Maximum slice: every AC address of 32 blocks exactly once.
    foreach (hits[i]) hits[i] = 0;
    do_start(32'd32);
    check("err_cleared_on_start", 64'(err), 64'd0);
    wr0 = wr_cnt;
    send_beats(32, 0, 2016, 1'b0);
    wait_done("bn32_done");
    check("bn32_write_count", 64'(wr_cnt - wr0), 64'd2016);
    bad = 0;
    for (int b = 0; b < 32; b++)
      for (int p = 0; p < 64; p++)
        if (hits[b * 64 + p] != ((p == 0) ? 0 : 1)) bad++;
    check("bn32_coverage_errors", 64'(bad), 64'd0);

    // Reset in the middle of a slice.
    do_start(32'd2);
    send_beats(2, 0, 50, 1'b0);
    reset_n = 1'b0;
    #1;
    check("midrun_reset_outputs", 64'({in_ready, mem_we, mem_addr, mem_wdata, done, err}), 64'd0);
    exp_q.delete();
    d0 = done_cnt;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
    check("no_done_after_reset", 64'(done_cnt - d0), 64'd0);
    check("idle_after_reset", 64'(in_ready), 64'd0);
    do_start(32'd2);
    wr0 = wr_cnt;
    send_beats(2, 0, 126, 1'b0);
    wait_done("post_reset_done");
    check("post_reset_write_count", 64'(wr_cnt - wr0), 64'd126);

    // start during RUN must not change the latched block count.
    do_start(32'd3);
    wr0 = wr_cnt;
    send_beats(3, 0, 20, 1'b0);
    do_start(32'd5);
    send_beats(3, 20, 169, 1'b0);
    wait_done("ignored_start_done");
    check("ignored_start_write_count", 64'(wr_cnt - wr0), 64'd189);

    repeat (2) @(negedge clock);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ac_vlc_to_mem.md
AC_VLC_TO_MEM -- requirements
Module: ac_vlc_to_mem

Interface
REQ-001 SHALL have parameter MAX_BLOCK_NUM, default 32: maximum blocks per slice.
REQ-002 SHALL have parameter MAX_PIXEL_NUM, default 64: coefficients per 8x8 block.
REQ-003 SHALL have port clock, input, 1 bit: rising-edge clock.
REQ-004 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1 bit: begin one slice; sampled only in IDLE.
REQ-006 SHALL have port block_num, input, 32 bits: blocks in slice, latched on start.
REQ-007 SHALL have port in_valid, input, 1 bit: in_data holds an AC coefficient.
REQ-008 SHALL have port in_data, input, 32 bits: decoded AC coefficient, scan order.
REQ-009 SHALL have port in_ready, output, 1 bit: block accepts a beat this cycle.
REQ-010 SHALL have port mem_we, output, 1 bit: write strobe to coefficient memory.
REQ-011 SHALL have port mem_addr, output, 11 bits: block*64 + natural position.
REQ-012 SHALL have port mem_wdata, output, 32 bits: coefficient to write.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse, slice complete.
REQ-014 SHALL have port err, output, 1 bit: sticky, illegal block_num; cleared on next accepted start.

Function
REQ-015 SHALL implement states IDLE, RUN, FLUSH; reset state IDLE.
REQ-016 IDLE: start=1 with 1<=block_num<=MAX_BLOCK_NUM SHALL latch block_num, clear counters k=1, b=0, clear err, go RUN.
REQ-017 IDLE: start=1 with block_num=0 or >MAX_BLOCK_NUM SHALL set err, pulse done next cycle, stay IDLE, issue no writes.
REQ-018 in_ready SHALL be 1 only in RUN; a beat is accepted when in_valid && in_ready.
REQ-019 Beat order SHALL be coefficient-major, block-minor: k=1..63 outer, b=0..block_num-1 inner; DC (k=0) is never received.
REQ-020 On accepted beat, the block SHALL in the next cycle drive mem_we=1, mem_addr=b*64+scan_pos(k), mem_wdata=in_data (1-cycle registered latency).
REQ-021 scan_pos SHALL be the 64-entry progressive scan table of the encoder-side reader (e.g. 0->0, 1->1, 2->8, 3->9, 4->2, 16->4, 35->48, 63->63).
REQ-022 Per accepted beat: b increments; at b=block_num-1 b wraps to 0 and k increments.
REQ-023 Accepted beat with k=63, b=block_num-1 SHALL move RUN->FLUSH; in_ready=0 from next cycle.
REQ-024 FLUSH SHALL last one cycle (final write visible), then pulse done=1 for one cycle on transition to IDLE.
REQ-025 in_valid=0 in RUN SHALL stall counters, mem_we=0 next cycle; no beat lost or duplicated.
REQ-026 start in RUN or FLUSH SHALL be ignored.
REQ-027 mem_we SHALL be 0 whenever no beat was accepted the previous cycle; mem_addr/mem_wdata hold last values.
REQ-028 Total writes per slice SHALL equal 63*block_num.

Reset
REQ-029 reset_n=0 SHALL asynchronously force state IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, done=0, err=0, k=1, b=0.
REQ-030 Reset mid-RUN SHALL abandon the slice; no done pulse; pending write dropped.

Structure
REQ-031 MAX_BLOCK_NUM, MAX_PIXEL_NUM and the scan_pos table/function SHALL live in a shared package (prores_scan_pkg) used by both reader and writer.
REQ-032 No sub-module; scan lookup SHALL be the package function, counters and FSM in one module.

Verification
REQ-033 block_num=2, 126 beats in_data=beat index, in_valid always 1 -> beat0 addr 1, beat1 addr 65, beat2 addr 8, beat125 addr 127 data 125; done 2 cycles after last accept.
REQ-034 block_num=1, random in_valid gaps -> exactly 63 writes, addresses = scan_pos(1..63), data order preserved.
REQ-035 block_num=0 and block_num=33 -> err=1, done pulse, zero mem_we, in_ready stays 0.
REQ-036 block_num=32 full slice -> 2016 writes covering every address b*64+1..63 exactly once, addr b*64 never written.
REQ-037 reset_n low after 50 beats -> outputs zero immediately, no done; new start completes normally.
REQ-038 start pulsed during RUN with different block_num -> ignored; slice completes with original count.
